fir_decim_out: RTL and testbench



---
 rtl/fir_pkg.sv | 41 ++++
 rtl/fir_sync_fifo.sv | 54 +++++
 rtl/fir_decim_out.sv | 135 +++++++++++++
 tb/tb_fir_decim_out.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM state type and rounding/saturation helpers
// for the FIR output stage. Rev 1.0
`default_nettype none

package fir_pkg;

  localparam int FIR_OUT_W  = 16;
  localparam int DROP_CNT_W = 8;
  localparam int CALC_W     = 64;

  typedef enum logic [0:0] {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Round half toward +inf, then arithmetic shift right; callers sign-extend into CALC_W.
  function automatic logic signed [CALC_W-1:0] round_shift(
    input logic signed [CALC_W-1:0] val,
    input int                       shift
  );
    logic signed [CALC_W-1:0] bias;
    bias = 64'sd1 <<< (shift - 1);
    return (val + bias) >>> shift;
  endfunction

  function automatic logic signed [CALC_W-1:0] saturate(
    input logic signed [CALC_W-1:0] val,
    input int                       width
  );
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (val > hi)      return hi;
    else if (val < lo) return lo;
    else               return val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo: small synchronous FIFO with combinational head output.
// Rev 1.0
`default_nettype none

module fir_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;
  logic [AW-1:0]    last_idx;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  // When empty, keep showing the entry that was popped last.
  assign last_idx = rd_ptr[AW-1:0] - AW'(1);
  assign dout     = empty ? mem[last_idx] : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_decim_out.sv
// fir_decim_out: warm-up discard, integrate-and-dump decimation, round/shift/
// saturate and FIFO output stage behind the 16-tap FIR. Rev 1.0
`default_nettype none

module fir_decim_out
  import fir_pkg::*;
#(
  parameter int DECIM  = 4,
  parameter int SHIFT  = 6,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 8,
  parameter int WARMUP = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic signed [FIR_OUT_W-1:0]  Yin,
  input  logic                         In_valid,
  output logic signed [OUT_W-1:0]      Dout,
  output logic                         Dout_valid,
  input  logic                         Dout_ready,
  output logic                         Overflow,
  output logic [DROP_CNT_W-1:0]        Drop_count
);

  localparam int ACC_W = 17 + $clog2(DECIM);
  localparam int PH_W  = $clog2(DECIM);
  localparam int WC_W  = $clog2(WARMUP + 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [WC_W-1:0]          warm_cnt;
  logic [PH_W-1:0]          phase;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  yin_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  stage_sum;
  logic                     stage_vld;
  logic signed [CALC_W-1:0] sum_ext;
  logic signed [OUT_W-1:0]  res;
  logic                     res_vld;
  logic                     run_valid;
  logic                     group_end;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     drop;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= WARM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WARM:    if (In_valid && (warm_cnt == WC_W'(WARMUP - 1))) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = WARM;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                             warm_cnt <= '0;
    else if ((state == WARM) && In_valid) warm_cnt <= warm_cnt + WC_W'(1);
  end

  assign yin_ext   = {{(ACC_W-FIR_OUT_W){Yin[FIR_OUT_W-1]}}, Yin};
  assign acc_sum   = acc + yin_ext;
  assign run_valid = (state == RUN) && In_valid;
  assign group_end = (phase == PH_W'(DECIM - 1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc       <= '0;
      phase     <= '0;
      stage_sum <= '0;
      stage_vld <= 1'b0;
    end else begin
      stage_vld <= run_valid && group_end;
      if (run_valid) begin
        if (group_end) begin
          stage_sum <= acc_sum;
          acc       <= '0;
          phase     <= '0;
        end else begin
          acc   <= acc_sum;
          phase <= phase + PH_W'(1);
        end
      end
    end
  end

  // Rounded/saturated result is registered once more before entering the FIFO.
  assign sum_ext = {{(CALC_W-ACC_W){stage_sum[ACC_W-1]}}, stage_sum};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      res     <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= stage_vld;
      if (stage_vld) res <= OUT_W'(saturate(round_shift(sum_ext, SHIFT), OUT_W));
    end
  end

  fir_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (res_vld),
    .din   (res),
    .pop   (Dout_ready),
    .dout  (Dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign Dout_valid = !fifo_empty;
  // Full implies non-empty, so a ready consumer always frees the slot in time.
  assign drop       = res_vld && fifo_full && !Dout_ready;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Overflow   <= 1'b0;
      Drop_count <= '0;
    end else if (drop) begin
      Overflow <= 1'b1;
      if (Drop_count != {DROP_CNT_W{1'b1}}) Drop_count <= Drop_count + DROP_CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_decim_out.sv
// tb_fir_decim_out: randomized and directed scoreboard bench for fir_decim_out.
`default_nettype none

module tb_fir_decim_out;

  localparam int DECIM  = 4;
  localparam int SHIFT  = 6;
  localparam int OUT_W  = 8;
  localparam int DEPTH  = 8;
  localparam int WARMUP = 16;

  logic                    Clk = 1'b0;
  logic                    Rst = 1'b1;
  logic signed [15:0]      Yin = '0;
  logic                    In_valid = 1'b0;
  logic                    Dout_ready = 1'b0;
  logic signed [OUT_W-1:0] Dout;
  logic                    Dout_valid;
  logic                    Overflow;
  logic [7:0]              Drop_count;

  always #5 Clk = ~Clk;

  fir_decim_out #(
    .DECIM(DECIM), .SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH), .WARMUP(WARMUP)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Yin(Yin), .In_valid(In_valid),
    .Dout(Dout), .Dout_valid(Dout_valid), .Dout_ready(Dout_ready),
    .Overflow(Overflow), .Drop_count(Drop_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: output = floor((sum + 2^(SHIFT-1)) / 2^SHIFT), clamped to OUT_W signed.
  function automatic int expected_out(input longint s);
    longint d, num, q, hi, lo;
    d   = longint'(1) << SHIFT;
    num = s + d / 2;
    q   = num / d;
    if ((num % d != 0) && (num < 0)) q = q - 1;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return int'(q);
  endfunction

  // Behavioural model: sample counter, group list, two-cycle result delay, FIFO occupancy.
  int     m_warm;
  longint m_grp[$];
  int     sb[$];
  int     m_count;
  int     m_ovf;
  int     m_drops;
  bit     p1_v, p2_v;
  int     p1_val, p2_val;
  bit     m_pop;
  longint m_sum;

  always @(posedge Clk) begin
    if (Rst) begin
      m_warm = 0; m_grp.delete(); sb.delete(); m_count = 0;
      m_ovf = 0; m_drops = 0; p1_v = 0; p2_v = 0;
    end else begin
      m_pop = (m_count > 0) && Dout_ready;
      if (p2_v) begin
        if ((m_count == DEPTH) && !m_pop) begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end else begin
          sb.push_back(p2_val);
          m_count++;
        end
      end
      if (m_pop) m_count--;
      p2_v = p1_v; p2_val = p1_val; p1_v = 0;
      if (In_valid) begin
        if (m_warm < WARMUP) m_warm++;
        else begin
          m_grp.push_back(longint'(Yin));
          if (m_grp.size() == DECIM) begin
            m_sum = 0;
            foreach (m_grp[i]) m_sum += m_grp[i];
            p1_v = 1; p1_val = expected_out(m_sum);
            m_grp.delete();
          end
        end
      end
    end
  end

  bit chk_const = 0;
  int exp_const = 0;
  int exp_v;

  always @(negedge Clk) begin
    if (!Rst) begin
      check("dout_valid", longint'(Dout_valid), longint'(m_count > 0));
      check("overflow", longint'(Overflow), longint'(m_ovf));
      check("drop_count", longint'(Drop_count), longint'(m_drops));
      if (Dout_valid && Dout_ready) begin
        if (sb.size() == 0) check("scoreboard_empty", 1, 0);
        else begin
          exp_v = sb.pop_front();
          check("dout", longint'(Dout), longint'(exp_v));
          if (chk_const) check("dout_const", longint'(Dout), longint'(exp_const));
        end
      end
    end
  end

  task automatic do_reset();
    Rst = 1'b1; In_valid = 1'b0; Dout_ready = 1'b0; chk_const = 0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic wait_first_valid(input int exp_edges, input int exp_val);
    int n = 0;
    while (!Dout_valid && n < 60) begin @(posedge Clk); #1; n++; end
    check("first_valid_edge", n, exp_edges);
    check("first_dout", longint'(Dout), exp_val);
  endtask

  task automatic wait_count(input int target);
    int n = 0;
    while (m_count != target && n < 600) begin @(posedge Clk); #1; n++; end
    check("fill_wait", longint'(n < 600), 1);
  endtask

  task automatic run_const(input int y, input int expv);
    do_reset();
    Yin = 16'(y); In_valid = 1'b1; Dout_ready = 1'b1;
    chk_const = 1; exp_const = expv;
    cycles(WARMUP + 10 * DECIM);
    chk_const = 0;
  endtask

  int n_hs;

  initial begin
    // Reset state
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_dout", longint'(Dout), 0);
    check("rst_valid", longint'(Dout_valid), 0);
    check("rst_overflow", longint'(Overflow), 0);
    check("rst_drops", longint'(Drop_count), 0);
    Rst = 1'b0;

    // Constant 100: first output after edge 20+2, value 6
    Yin = 16'sd100; In_valid = 1'b1; Dout_ready = 1'b1;
    chk_const = 1; exp_const = 6;
    wait_first_valid(WARMUP + DECIM + 2, 6);
    cycles(12 * DECIM);
    chk_const = 0;

    // Rounding and saturation
    run_const(8, 1);
    run_const(-8, 0);
    run_const(1000, 63);
    run_const(10000, 127);
    run_const(-10000, -128);

    // Backpressure: fill, drop, saturate drop counter, then drain in order
    do_reset();
    In_valid = 1'b1; Dout_ready = 1'b0;
    repeat (WARMUP + 300 * DECIM + 4) begin
      Yin = 16'($signed($urandom_range(0, 8000)) - 4000);
      @(posedge Clk); #1;
    end
    check("bp_drops_sat", longint'(Drop_count), 255);
    check("bp_overflow", longint'(Overflow), 1);
    In_valid = 1'b0; Dout_ready = 1'b1;
    cycles(DEPTH + 6);
    check("bp_drained", longint'(Dout_valid), 0);

    // Full FIFO with a pop aligned to every push: no drops, occupancy stays DEPTH
    do_reset();
    In_valid = 1'b1; Dout_ready = 1'b0;
    Yin = 16'($signed($urandom_range(0, 2000)) - 1000);
    wait_count(DEPTH);
    repeat (10 * DECIM) begin
      Yin = 16'($signed($urandom_range(0, 2000)) - 1000);
      Dout_ready = p2_v;
      @(posedge Clk); #1;
    end
    while (p1_v || p2_v) begin Dout_ready = p2_v; @(posedge Clk); #1; end
    In_valid = 1'b0; Dout_ready = 1'b0;
    cycles(DECIM + 2);
    check("fullpop_drops", longint'(Drop_count), 0);
    check("fullpop_valid", longint'(Dout_valid), 1);
    Dout_ready = 1'b1;
    n_hs = 0;
    repeat (DEPTH + 6) begin
      @(negedge Clk);
      if (Dout_valid) n_hs++;
      @(posedge Clk); #1;
    end
    check("fullpop_occupancy", n_hs, DEPTH);

    // Mid-operation asynchronous reset with three entries stored
    do_reset();
    Yin = 16'sd100; In_valid = 1'b1; Dout_ready = 1'b0;
    wait_count(3);
    #1 Rst = 1'b1;
    #1;
    check("midrst_valid", longint'(Dout_valid), 0);
    check("midrst_overflow", longint'(Overflow), 0);
    check("midrst_drops", longint'(Drop_count), 0);
    @(posedge Clk); #1 Rst = 1'b0;
    Dout_ready = 1'b1;
    wait_first_valid(WARMUP + DECIM + 2, 6);

    // Randomized traffic with varying backpressure
    do_reset();
    for (int ep = 0; ep < 15; ep++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(5, 100);
      repeat (200) begin
        In_valid   = ($urandom_range(0, 3) != 0);
        Yin        = ($urandom_range(0, 1) != 0) ? 16'($urandom)
                                                 : 16'($signed($urandom_range(0, 800)) - 400);
        Dout_ready = ($urandom_range(1, 100) <= rdy_pct);
        @(posedge Clk); #1;
      end
    end
    In_valid = 1'b0; Dout_ready = 1'b1;
    cycles(DEPTH + 8);
    check("random_sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
